// File: rtl/ifetch_sequencer.sv
// Instruction fetch sequencer: walks a byte PC through a word-addressed ROM and
// buffers {pc, word} pairs in a 2-entry FIFO, with redirect flush and a sticky fault state.
module ifetch_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic [5:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [7:0]  inst_pc,
  output logic        fault
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_pc;
  logic [1:0]  r_cnt;
  logic        r_fault;
  logic [7:0]  r_e0_pc;
  logic [31:0] r_e0_data;
  logic [7:0]  r_e1_pc;
  logic [31:0] r_e1_data;

  logic w_pop;
  logic w_issue;
  logic w_redir_ok;
  logic w_redir_bad;
  logic w_flush;

  assign rom_addr   = r_pc[7:2];
  assign inst_valid = (r_cnt != 2'd0) && (r_state != ST_FAULT);
  assign inst_data  = r_e0_data;
  assign inst_pc    = r_e0_pc;
  assign fault      = r_fault;

  // Redirect decode, issue qualification and next-state selection
  always_comb begin
    w_pop       = inst_valid && inst_ready;
    w_redir_ok  = 1'b0;
    w_redir_bad = 1'b0;
    if (redirect_valid && (r_state != ST_FAULT)) begin
      w_redir_ok  = (redirect_pc[1:0] == 2'b00);
      w_redir_bad = (redirect_pc[1:0] != 2'b00);
    end else begin
      w_redir_ok  = 1'b0;
      w_redir_bad = 1'b0;
    end
    w_flush = w_redir_ok || w_redir_bad;
    w_issue = (r_state == ST_FETCH) && ((r_cnt != 2'd2) || w_pop) && !redirect_valid;

    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_redir_bad)      w_state_nxt = ST_FAULT;
        else if (w_redir_ok)  w_state_nxt = ST_IDLE;
        else if (run)         w_state_nxt = ST_FETCH;
        else                  w_state_nxt = ST_IDLE;
      end
      ST_FETCH: begin
        if (w_redir_bad)      w_state_nxt = ST_FAULT;
        else if (w_redir_ok)  w_state_nxt = ST_FETCH;
        else if (!run)        w_state_nxt = ST_IDLE;
        else                  w_state_nxt = ST_FETCH;
      end
      ST_FAULT: w_state_nxt = ST_FAULT;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State, PC and fault registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_redir_ok)   r_pc <= redirect_pc;
      else if (w_issue) r_pc <= r_pc + 8'd4;
      if (w_redir_bad)  r_fault <= 1'b1;
    end
  end

  // FIFO storage: entry 0 is always the head so the outputs come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 2'd0;
      r_e0_pc   <= 8'h00;
      r_e0_data <= 32'h0000_0000;
      r_e1_pc   <= 8'h00;
      r_e1_data <= 32'h0000_0000;
    end else if (w_flush) begin
      r_cnt <= 2'd0;
    end else begin
      case ({w_issue, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_e0_pc   <= r_pc;
            r_e0_data <= rom_data;
          end else begin
            r_e1_pc   <= r_pc;
            r_e1_data <= rom_data;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_e0_pc   <= r_e1_pc;
          r_e0_data <= r_e1_data;
          r_cnt     <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_e0_pc   <= r_pc;
            r_e0_data <= rom_data;
          end else begin
            r_e0_pc   <= r_e1_pc;
            r_e0_data <= r_e1_data;
            r_e1_pc   <= r_pc;
            r_e1_data <= rom_data;
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Directed bench for ifetch_sequencer: a negedge monitor checks every delivered
// instruction against a scoreboard queue filled by the stimulus sequence.
module tb_ifetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [7:0]  inst_pc;
  logic        fault;

  logic [31:0] rom [64];
  logic [39:0] q [$];
  int total = 0;
  int bad   = 0;

  ifetch_sequencer #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  // ROM samples its address on the falling edge
  always @(negedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] ent(input logic [7:0] pc);
    return {pc, rom[pc[7:2]]};
  endfunction

  task automatic expect_seq(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) q.push_back(ent(start + 8'(4 * i)));
  endtask

  // Every accepted head is compared with the oldest expected entry
  always @(negedge clk) begin
    if (rst_n === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
      if (q.size() == 0) chk("spurious_delivery", {inst_pc, inst_data}, 40'h0);
      else chk("deliver", {inst_pc, inst_data}, q.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hC0DE_0000 | 32'(i);
    rom[0] = 32'hE3A00004;
    rom[1] = 32'hE3A01001;
    rst_n = 1'b0; run = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; inst_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 40'(inst_valid), 40'h0);
    chk("rst_fault", 40'(fault), 40'h0);
    chk("rst_addr", 40'(rom_addr), 40'h0);
    chk("rst_data", 40'(inst_data), 40'h0);
    chk("rst_pc", 40'(inst_pc), 40'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_no_issue", 40'(inst_valid), 40'h0);
    chk("idle_addr", 40'(rom_addr), 40'h0);

    // streaming, then stop: the issue in the run=0 cycle still lands
    expect_seq(8'h00, 6);
    run = 1'b1; inst_ready = 1'b1;
    tick();
    chk("stream_lat0", 40'(inst_valid), 40'h0);
    tick();
    chk("stream_lat1", 40'(inst_valid), 40'h1);
    chk("stream_first_pc", 40'(inst_pc), 40'h00);
    repeat (4) tick();
    run = 1'b0;
    repeat (4) tick();
    chk("stream_drained", 40'(q.size()), 40'h0);
    chk("stream_idle_valid", 40'(inst_valid), 40'h0);
    chk("stream_idle_addr", 40'(rom_addr), 40'h06);

    // redirect in IDLE back to 0, then backpressure
    inst_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 8'h00;
    tick();
    redirect_valid = 1'b0;
    chk("idle_redir_addr", 40'(rom_addr), 40'h00);
    chk("idle_redir_valid", 40'(inst_valid), 40'h0);
    run = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 40'(inst_valid), 40'h1);
      chk("bp_head_pc", 40'(inst_pc), 40'h00);
      chk("bp_head_data", 40'(inst_data), 40'hE3A00004);
      chk("bp_pc_hold", 40'(rom_addr), 40'h02);
    end
    expect_seq(8'h00, 4);
    inst_ready = 1'b1;
    repeat (4) tick();
    inst_ready = 1'b0;
    tick();
    chk("bp_release_addr", 40'(rom_addr), 40'h06);
    chk("bp_release_head", 40'(inst_pc), 40'h10);

    // redirect with a full FIFO
    redirect_valid = 1'b1; redirect_pc = 8'h30;
    tick();
    redirect_valid = 1'b0;
    chk("redir_flush_valid", 40'(inst_valid), 40'h0);
    chk("redir_addr", 40'(rom_addr), 40'h0C);
    expect_seq(8'h30, 3);
    inst_ready = 1'b1;
    repeat (4) tick();
    inst_ready = 1'b0;
    chk("redir_drained", 40'(q.size()), 40'h0);

    // PC wrap past 0xFC
    redirect_valid = 1'b1; redirect_pc = 8'hF8;
    tick();
    redirect_valid = 1'b0;
    expect_seq(8'hF8, 4);
    inst_ready = 1'b1;
    repeat (5) tick();
    inst_ready = 1'b0;
    chk("wrap_drained", 40'(q.size()), 40'h0);

    // asynchronous reset with one entry held
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("pre_rst_count1", 40'(inst_valid), 40'h1);
    chk("pre_rst_pc", 40'(inst_pc), 40'h40);
    #2;
    rst_n = 1'b0; run = 1'b0;
    #1;
    chk("arst_valid", 40'(inst_valid), 40'h0);
    chk("arst_pc", 40'(inst_pc), 40'h0);
    chk("arst_data", 40'(inst_data), 40'h0);
    chk("arst_addr", 40'(rom_addr), 40'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_no_issue", 40'(inst_valid), 40'h0);
    run = 1'b1;
    tick(); tick();
    chk("post_rst_valid", 40'(inst_valid), 40'h1);
    chk("post_rst_head", {inst_pc, inst_data}, 40'h00_E3A00004);
    tick(); tick();

    // misaligned redirect locks into FAULT
    redirect_valid = 1'b1; redirect_pc = 8'h31;
    tick();
    redirect_valid = 1'b0;
    chk("fault_set", 40'(fault), 40'h1);
    chk("fault_valid", 40'(inst_valid), 40'h0);
    chk("fault_pc_hold", 40'(rom_addr), 40'h02);
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    repeat (3) tick();
    chk("fault_sticky", 40'(fault), 40'h1);
    chk("fault_still_invalid", 40'(inst_valid), 40'h0);
    chk("fault_redir_ignored", 40'(rom_addr), 40'h02);
    rst_n = 1'b0;
    #1;
    chk("fault_cleared", 40'(fault), 40'h0);
    chk("final_queue", 40'(q.size()), 40'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_sequencer.md
IFETCH_SEQUENCER -- requirements
Module: ifetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, meaning the byte address loaded into the PC at reset; RESET_PC[1:0] is 2'b00.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port run, input, 1 bit: 1 = fetch enabled, 0 = stop issuing.
REQ-005 SHALL have port redirect_valid, input, 1 bit: one-cycle branch/exception redirect strobe.
REQ-006 SHALL have port redirect_pc, input, 8 bits: byte address of the redirect target.
REQ-007 SHALL have port rom_addr, output, 6 bits: word address to the instruction ROM, equal to pc[7:2].
REQ-008 SHALL have port rom_data, input, 32 bits: ROM read data, which the ROM samples on negedge and which is stable by the next posedge.
REQ-009 SHALL have port inst_valid, output, 1 bit: FIFO head holds an instruction.
REQ-010 SHALL have port inst_ready, input, 1 bit: consumer accepts the head this cycle.
REQ-011 SHALL have port inst_data, output, 32 bits: instruction word at the FIFO head.
REQ-012 SHALL have port inst_pc, output, 8 bits: byte address of the instruction at the FIFO head.
REQ-013 SHALL have port fault, output, 1 bit: sticky misaligned-redirect indicator.

Function
REQ-014 SHALL implement states IDLE, FETCH and FAULT, plus a 2-entry FIFO of {pc[7:0], data[31:0]} with a count of 0..2.
REQ-015 SHALL drive rom_addr continuously from the registered PC, without a combinational path from any input.
REQ-016 SHALL define pop = inst_valid && inst_ready, and inst_valid = (count != 0) && state != FAULT.
REQ-017 SHALL, in FETCH, issue in a cycle when count < 2 or pop is 1, and redirect_valid is 0.
REQ-018 SHALL, on an issue, at the posedge ending that cycle, push {pc, rom_data} and set pc <= pc + 4 modulo 256 (8'hFC wraps to 8'h00); latency from PC presentation to FIFO entry is 1 cycle.
REQ-019 SHALL support push and pop in the same cycle, leaving count unchanged and preserving FIFO order.
REQ-020 SHALL hold pc and push nothing when count == 2 and pop is 0 (stall).
REQ-021 SHALL, on redirect_valid with redirect_pc[1:0] == 0, flush the FIFO (count <= 0), discard that cycle's issue, and load pc <= redirect_pc; the state is unchanged.
REQ-022 SHALL give redirect priority over pop and push; a pop in the redirect cycle is still considered accepted by the consumer.
REQ-023 SHALL, on redirect_valid with redirect_pc[1:0] != 0, in any state, go to FAULT with fault <= 1, flush the FIFO, and leave pc unchanged.
REQ-024 SHALL keep FAULT terminal until rst_n is asserted, with no issue, inst_valid = 0, and redirects ignored.
REQ-025 SHALL transition IDLE -> FETCH at the posedge where run = 1, with the first issue in the following cycle.
REQ-026 SHALL transition FETCH -> IDLE at the posedge where run = 0; an issue in that same cycle still completes, and the FIFO drains via pop in IDLE.
REQ-027 SHALL, in IDLE, still apply a redirect (flush and pc load), remaining in IDLE.
REQ-028 SHALL hold inst_data and inst_pc constant while inst_valid = 1 and inst_ready = 0.

Reset
REQ-029 SHALL, while rst_n = 0, immediately set state = IDLE, pc = RESET_PC, count = 0, fault = 0, inst_valid = 0, and rom_addr = RESET_PC[7:2].
REQ-030 SHALL set inst_data and inst_pc to 0 during reset.
REQ-031 SHALL, on an asynchronous reset assertion mid-fetch, discard the in-flight issue and all FIFO contents.
REQ-032 SHALL resume at the first posedge after rst_n deasserts, with no issue until run = 1 is sampled.

Verification
REQ-033 SHALL cover streaming: ROM word0 = 32'hE3A00004, word1 = 32'hE3A01001; run = 1 and inst_ready = 1 -> inst_valid rises 2 cycles after run is sampled, and the bench sees (pc 0x00, E3A00004), (0x04, E3A01001), then one instruction per cycle.
REQ-034 SHALL cover backpressure: inst_ready = 0 for 5 cycles -> count saturates at 2, pc is held at 0x08, the head stays (0x00, E3A00004), and there are no drops or duplicates after release.
REQ-035 SHALL cover redirect: redirect_pc = 0x30 while count = 2 -> inst_valid = 0 on the next cycle, the next delivered inst_pc = 0x30, and the pre-redirect entries are never delivered.
REQ-036 SHALL cover misaligned redirect: redirect_pc = 0x31 -> fault = 1 and inst_valid = 0 on the next cycle, persisting until reset.
REQ-037 SHALL cover wrap: redirect to 0xF8 -> delivered inst_pc sequence is 0xF8, 0xFC, 0x00, 0x04.
REQ-038 SHALL cover reset mid-operation: rst_n = 0 asserted between posedges with count = 1 -> outputs reach their reset values without waiting for a clock edge, and the post-reset sequence starts at 0x00.
